// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with a registered read port,
// programmable almost-full/almost-empty thresholds, one-cycle overflow and
// underflow pulses, a read-valid strobe and a synchronous flush.
// The occupancy counter is kept in its own register so that full and empty
// are never inferred from the pointers, which coincide in both cases.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   counter,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Storage and state registers
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Decoded controls
    logic             full_s;
    logic             empty_s;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             mem_we_s;

    assign full_s  = (cnt_q == DEPTH_C);
    assign empty_s = (cnt_q == {CW{1'b0}});

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign counter      = cnt_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Next-state logic: accept/reject push and pop, update pointers and count
    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        mem_we_s     = 1'b0;

        // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
        rd_ok_s = rd_en && !empty_s;
        wr_ok_s = wr_en && (!full_s || rd_ok_s);

        if (flush) begin
            // Contents are discarded; dout and memory keep their values.
            wp_d  = {AW{1'b0}};
            rp_d  = {AW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_we_s = 1'b1;
                wp_d     = wp_q + AW'(1);
            end else begin
                mem_we_s = 1'b0;
            end

            if (rd_ok_s) begin
                dout_d       = mem_q[rp_q];
                rp_d         = rp_q + AW'(1);
                dout_valid_d = 1'b1;
            end else begin
                dout_valid_d = 1'b0;
            end

            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase

            overflow_d  = wr_en && !wr_ok_s;
            underflow_d = rd_en && !rd_ok_s;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= {AW{1'b0}};
            rp_q         <= {AW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Memory write port; the array is never cleared
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[wp_q] <= din;
        end
    end

endmodule
